// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin burst arbiter driving a shared tristate bus
module tristate_bus_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*WIDTH-1:0]     data_in,
  input  logic                     ext_oe,
  input  logic                     clr_contention,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_oe,
  output logic [NCH-1:0]           ack,
  output logic [$clog2(NCH)-1:0]   owner,
  output logic                     busy,
  output logic                     contention
);

  localparam int OW = $clog2(NCH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  localparam logic [BW-1:0] BEAT_LAST   = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST   = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam state_t        AFTER_BURST = (TURN_CYC == 0) ? IDLE : TURN;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   cand;
  logic            found;
  logic            drive;
  logic [WIDTH-1:0] chan [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan[i] = data_in[i*WIDTH +: WIDTH];
  end

  // Round-robin search: first requester after the last owner, wrapping around
  always_comb begin
    winner = owner;
    found  = 1'b0;
    cand   = owner;
    for (int k = 1; k <= NCH; k++) begin
      cand = OW'((int'(owner) + k) % NCH);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // A beat happens only while the owner keeps its request up during DRIVE
  always_comb begin
    drive = (state == DRIVE) && req[owner];
    for (int i = 0; i < NCH; i++) begin
      ack[i] = drive && (owner == OW'(i));
    end
  end

  assign bus_oe  = drive;
  assign bus_out = drive ? chan[owner] : {WIDTH{1'bz}};
  assign busy    = (state != IDLE);

  // Arbitration FSM, burst/turnaround counters and sticky contention flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OW'(NCH - 1);
      beat_cnt   <= '0;
      turn_cnt   <= '0;
      contention <= 1'b0;
    end else begin
      // Set beats clear when both happen on the same edge
      if (bus_oe && ext_oe) begin
        contention <= 1'b1;
      end else if (clr_contention) begin
        contention <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (req[owner]) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_LAST) begin
              turn_cnt <= '0;
              state    <= AFTER_BURST;
            end
          end else begin
            // Dropped request ends the burst; it is never resumed mid-burst
            turn_cnt <= '0;
            state    <= AFTER_BURST;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - directed-vector bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        ext_oe;
  logic        clr_contention;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        busy;
  logic        contention;

  int vectors = 0;
  int miscompares = 0;

  tristate_bus_arbiter #(.WIDTH(8), .NCH(4), .MAX_BURST(4), .TURN_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ext_oe(ext_oe),
    .clr_contention(clr_contention), .bus_out(bus_out), .bus_oe(bus_oe),
    .ack(ack), .owner(owner), .busy(busy), .contention(contention)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; data_in = '0; ext_oe = 1'b0; clr_contention = 1'b0;
    @(negedge clk);
    vectors++; if (bus_oe !== 1'b0) begin miscompares++; $display("FAIL reset_bus_oe got %b want 0", bus_oe); end
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got %b want 0000", ack); end
    vectors++; if (owner !== 2'd3) begin miscompares++; $display("FAIL reset_owner got %0d want 3", owner); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (contention !== 1'b0) begin miscompares++; $display("FAIL reset_contention got %b want 0", contention); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    cyc();
  endtask

  task automatic test_short_burst;
    logic [5:0] exp_oe   = 6'b000110;
    logic [5:0] exp_busy = 6'b011110;
    data_in[23:16] = 8'hA5;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) req = 4'b0100;
      if (k == 3) req = 4'b0000;
      @(negedge clk);
      vectors++; if (bus_oe !== exp_oe[k]) begin miscompares++; $display("FAIL short_oe[%0d] got %b want %b", k, bus_oe, exp_oe[k]); end
      vectors++; if (ack !== (exp_oe[k] ? 4'b0100 : 4'b0000)) begin miscompares++; $display("FAIL short_ack[%0d] got %b want %b", k, ack, exp_oe[k] ? 4'b0100 : 4'b0000); end
      vectors++; if (busy !== exp_busy[k]) begin miscompares++; $display("FAIL short_busy[%0d] got %b want %b", k, busy, exp_busy[k]); end
      if (exp_oe[k]) begin
        vectors++; if (bus_out !== 8'hA5) begin miscompares++; $display("FAIL short_data[%0d] got %h want a5", k, bus_out); end
      end
      cyc();
    end
    vectors++; if (owner !== 2'd2) begin miscompares++; $display("FAIL short_owner got %0d want 2", owner); end
  endtask

  task automatic test_burst_cap;
    logic [11:0] exp_oe = 12'b011110011110;
    for (int k = 0; k < 12; k++) begin
      req = 4'b0010;
      data_in[15:8] = 8'h10 + 8'(k);
      @(negedge clk);
      vectors++; if (bus_oe !== exp_oe[k]) begin miscompares++; $display("FAIL cap_oe[%0d] got %b want %b", k, bus_oe, exp_oe[k]); end
      vectors++; if (ack !== (exp_oe[k] ? 4'b0010 : 4'b0000)) begin miscompares++; $display("FAIL cap_ack[%0d] got %b want %b", k, ack, exp_oe[k] ? 4'b0010 : 4'b0000); end
      if (exp_oe[k]) begin
        vectors++; if (bus_out !== 8'h10 + 8'(k)) begin miscompares++; $display("FAIL cap_data[%0d] got %h want %h", k, bus_out, 8'h10 + 8'(k)); end
      end
      cyc();
    end
    req = 4'b0000;
    @(negedge clk);
    vectors++; if (owner !== 2'd1) begin miscompares++; $display("FAIL cap_owner got %0d want 1", owner); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cap_busy got %b want 0", busy); end
    cyc();
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_ack [23] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                                 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0,
                                 4'h1, 4'h1, 4'h1, 4'h1};
    logic [7:0] exp_data;
    apply_reset();
    data_in = 32'h3D2C1B0A;
    req = 4'b1011;
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      vectors++; if (ack !== exp_ack[k]) begin miscompares++; $display("FAIL rr_ack[%0d] got %b want %b", k, ack, exp_ack[k]); end
      vectors++; if (bus_oe !== (exp_ack[k] != 4'h0)) begin miscompares++; $display("FAIL rr_oe[%0d] got %b want %b", k, bus_oe, exp_ack[k] != 4'h0); end
      if (exp_ack[k] != 4'h0) begin
        case (exp_ack[k])
          4'h1:    exp_data = 8'h0A;
          4'h2:    exp_data = 8'h1B;
          default: exp_data = 8'h3D;
        endcase
        vectors++; if (bus_out !== exp_data) begin miscompares++; $display("FAIL rr_data[%0d] got %h want %h", k, bus_out, exp_data); end
      end
      cyc();
    end
    req = 4'b0000;
    cyc();
    cyc();
  endtask

  task automatic test_contention;
    apply_reset();
    data_in = 32'h0000000A;
    req = 4'b0001;
    @(negedge clk);
    vectors++; if (contention !== 1'b0) begin miscompares++; $display("FAIL cont_k0 got %b want 0", contention); end
    cyc();
    ext_oe = 1'b1;
    @(negedge clk);
    vectors++; if (bus_oe !== 1'b1) begin miscompares++; $display("FAIL cont_k1_oe got %b want 1", bus_oe); end
    cyc();
    ext_oe = 1'b0;
    @(negedge clk);
    vectors++; if (contention !== 1'b1) begin miscompares++; $display("FAIL cont_set got %b want 1", contention); end
    cyc();
    clr_contention = 1'b1;
    @(negedge clk);
    vectors++; if (contention !== 1'b1) begin miscompares++; $display("FAIL cont_sticky got %b want 1", contention); end
    cyc();
    ext_oe = 1'b1;
    @(negedge clk);
    vectors++; if (contention !== 1'b0) begin miscompares++; $display("FAIL cont_clear got %b want 0", contention); end
    vectors++; if (bus_oe !== 1'b1) begin miscompares++; $display("FAIL cont_k4_oe got %b want 1", bus_oe); end
    cyc();
    @(negedge clk);
    vectors++; if (contention !== 1'b1) begin miscompares++; $display("FAIL cont_set_wins got %b want 1", contention); end
    vectors++; if (bus_oe !== 1'b0) begin miscompares++; $display("FAIL cont_turn_oe got %b want 0", bus_oe); end
    cyc();
    clr_contention = 1'b0; ext_oe = 1'b0; req = 4'b0000;
    @(negedge clk);
    vectors++; if (contention !== 1'b0) begin miscompares++; $display("FAIL cont_ext_only got %b want 0", contention); end
    cyc();
    @(negedge clk);
    vectors++; if (contention !== 1'b0) begin miscompares++; $display("FAIL cont_hold0 got %b want 0", contention); end
    cyc();
  endtask

  task automatic test_async_reset;
    apply_reset();
    data_in = 32'h0000005C;
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL ar_beat[%0d] got %b want 0001", k, ack); end
      end
      cyc();
    end
    vectors++; if (bus_oe !== 1'b1) begin miscompares++; $display("FAIL ar_pre_oe got %b want 1", bus_oe); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus_oe !== 1'b0) begin miscompares++; $display("FAIL ar_oe got %b want 0", bus_oe); end
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL ar_ack got %b want 0000", ack); end
    vectors++; if (owner !== 2'd3) begin miscompares++; $display("FAIL ar_owner got %0d want 3", owner); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy got %b want 0", busy); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL ar_idle_ack got %b want 0000", ack); end
    cyc();
    @(negedge clk);
    vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL ar_regrant_ack got %b want 0001", ack); end
    vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL ar_regrant_owner got %0d want 0", owner); end
    vectors++; if (bus_out !== 8'h5C) begin miscompares++; $display("FAIL ar_regrant_data got %h want 5c", bus_out); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_short_burst();
    test_burst_cap();
    test_round_robin();
    test_contention();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
